// File: rtl/conv_frame_feeder.sv
// Frame feeder for the convolutional encoder: it pulls bytes over valid/ready and emits them MSB-first as spaced bit_en pulses.
// Define CONV_FEEDER_TAIL_FLUSH_EN to append the K-1 zero tail bits that flush the encoder trellis.
//   state     | meaning
//   IDLE      | waiting for frame_start with a nonzero length
//   WAIT_BYTE | s_ready high, waiting for the next byte
//   SHIFT     | one bit_en pulse carrying the current MSB
//   GAP_WAIT  | GAP idle cycles after each data pulse
//   TAIL      | zero tail pulses plus their gaps (tail build only)
//   DONE      | one-cycle frame_done
module conv_frame_feeder #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [1:0]        sel_in,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              data_out,
  output logic              bit_en,
  output logic [1:0]        constraint_sel_out,
  output logic              busy,
  output logic              tail_active,
  output logic              frame_done
);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT     = 3'd2,
    GAP_WAIT  = 3'd3,
    DONE      = 3'd4
`ifdef CONV_FEEDER_TAIL_FLUSH_EN
    , TAIL    = 3'd5
`endif
  } state_t;

  state_t            state, state_n;
  logic [LEN_W-1:0]  byte_cnt, byte_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [DATA_W-1:0] shreg, sh_n;
  logic [1:0]        sel_n;
  logic              pulse_n, data_n;

`ifdef CONV_FEEDER_TAIL_FLUSH_EN
  logic [2:0] tail_cnt, tail_n;

  function automatic logic [2:0] tail_len(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3'd2;
      2'b01:   return 3'd3;
      2'b10:   return 3'd4;
      default: return 3'd6;
    endcase
  endfunction
`endif

  assign s_ready = (state == WAIT_BYTE);

  // Outputs are registered, so each pulse is decided one cycle ahead from the next state.
  always_comb begin
    state_n = state;
    byte_n  = byte_cnt;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    sh_n    = shreg;
    sel_n   = constraint_sel_out;
    pulse_n = 1'b0;
    data_n  = 1'b0;
`ifdef CONV_FEEDER_TAIL_FLUSH_EN
    tail_n  = tail_cnt;
`endif
    case (state)
      IDLE: begin
        if (frame_start && frame_len != '0) begin
          byte_n  = frame_len;
          sel_n   = sel_in;
          state_n = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (s_valid) begin
          sh_n    = s_data;
          bit_n   = BIT_W'(DATA_W);
          if (byte_cnt != '0) byte_n = byte_cnt - LEN_W'(1);
          state_n = SHIFT;
          pulse_n = 1'b1;
          data_n  = s_data[DATA_W-1];
        end
      end
      SHIFT: begin
        sh_n    = shreg << 1;
        bit_n   = bit_cnt - BIT_W'(1);
        gap_n   = GAP_W'(GAP);
        state_n = GAP_WAIT;
      end
      GAP_WAIT: begin
        gap_n = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) begin
          if (bit_cnt != '0) begin
            state_n = SHIFT;
            pulse_n = 1'b1;
            data_n  = shreg[DATA_W-1];
          end else if (byte_cnt != '0) begin
            state_n = WAIT_BYTE;
          end else begin
`ifdef CONV_FEEDER_TAIL_FLUSH_EN
            state_n = TAIL;
            tail_n  = tail_len(constraint_sel_out);
            pulse_n = 1'b1;
`else
            state_n = DONE;
`endif
          end
        end
      end
`ifdef CONV_FEEDER_TAIL_FLUSH_EN
      // gap_cnt==0 marks the pulse cycle of a tail bit; nonzero counts its gap.
      TAIL: begin
        if (gap_cnt == '0) begin
          gap_n  = GAP_W'(GAP);
          tail_n = tail_cnt - 3'd1;
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            if (tail_cnt == 3'd0) state_n = DONE;
            else pulse_n = 1'b1;
          end
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      bit_cnt            <= '0;
      gap_cnt            <= '0;
      shreg              <= '0;
      constraint_sel_out <= 2'b00;
      bit_en             <= 1'b0;
      data_out           <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      state              <= state_n;
      byte_cnt           <= byte_n;
      bit_cnt            <= bit_n;
      gap_cnt            <= gap_n;
      shreg              <= sh_n;
      constraint_sel_out <= sel_n;
      bit_en             <= pulse_n;
      data_out           <= data_n;
      busy               <= (state_n != IDLE);
      frame_done         <= (state_n == DONE);
    end
  end

`ifdef CONV_FEEDER_TAIL_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_cnt    <= 3'd0;
      tail_active <= 1'b0;
    end else begin
      tail_cnt    <= tail_n;
      tail_active <= (state_n == TAIL);
    end
  end
`else
  assign tail_active = 1'b0;
`endif

endmodule
